// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch resolve / predict slice.
// Op codes, BHT counter states and the saturating update rule.
package branch_predict_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BGEZ = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLEZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam logic [1:0] BHT_RESET = WNT;

  function automatic logic [1:0] bht_next(
    input logic [1:0] s,
    input logic       taken
  );
    logic [1:0] n;
    n = s;
    if (taken && s != ST)
      n = s + 2'd1;
    else if (!taken && s != SNT)
      n = s - 2'd1;
    return n;
  endfunction

  function automatic logic op_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: (op, rs, rt) -> taken.
// Signed compares on rs; reserved ops never take.
module branch_cond_eval
  import branch_predict_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  output logic              taken_o
);

  logic rs_neg;
  logic rs_zero;
  logic eq;

  assign rs_neg  = rs_i[DATA_W-1];
  assign rs_zero = (rs_i == '0);
  assign eq      = (rs_i == rt_i);

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      BR_BEQ:  taken_o = eq;
      BR_BNE:  taken_o = !eq;
      BR_BGEZ: taken_o = !rs_neg;
      BR_BGTZ: taken_o = !rs_neg && !rs_zero;
      BR_BLEZ: taken_o = rs_neg || rs_zero;
      BR_BLTZ: taken_o = rs_neg;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve in EX, 2-bit BHT prediction at IF,
// registered mispredict redirect and mispredict statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             accept;
  logic             taken;
  logic             bht_we;
  logic [1:0]       bht_d;
  logic             mispred_d;
  logic [PC_W-1:0]  redirect_d;

  logic             res_valid_q;
  logic             res_taken_q;
  logic             mispred_q;
  logic [PC_W-1:0]  redirect_q;
  logic [CNT_W-1:0] cnt_q;

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[PC_W-1:IDX_W+2]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .op_i    (ex_op),
    .rs_i    (ex_rs),
    .rt_i    (ex_rt),
    .taken_o (taken)
  );

  // Lookup reads the pre-update entry; no bypass from EX.
  assign if_pred_taken = bht_q[if_idx][1];

  assign accept     = ex_valid & ~ex_stall;
  assign bht_we     = accept & ~op_reserved(ex_op);
  assign bht_d      = bht_next(bht_q[ex_idx], taken);
  assign mispred_d  = accept & (taken != ex_pred_taken);
  assign redirect_d = taken ? ex_target : ex_pc + PC_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht_q[i] <= BHT_RESET;
    end else if (bht_we) begin
      bht_q[ex_idx] <= bht_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      mispred_q   <= 1'b0;
      redirect_q  <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        res_taken_q <= taken;
        mispred_q   <= mispred_d;
        redirect_q  <= redirect_d;
      end
    end
  end

  // Counted at resolve so it moves in step with the mispredict flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (mispred_d && cnt_q != '1)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign mispredict  = res_valid_q & mispred_q;
  assign redirect_pc = redirect_q;
  assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed corners
// plus random branches against a behavioural predictor model.
module tb_branch_predict_unit;

  localparam int DW  = 32;
  localparam int PW  = 32;
  localparam int DEP = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] if_pc;
  logic          if_pred_taken;
  logic          ex_valid;
  logic          ex_stall;
  logic [2:0]    ex_op;
  logic [DW-1:0] ex_rs;
  logic [DW-1:0] ex_rt;
  logic [PW-1:0] ex_pc;
  logic [PW-1:0] ex_target;
  logic          ex_pred_taken;
  logic          res_valid;
  logic          res_taken;
  logic          mispredict;
  logic [PW-1:0] redirect_pc;
  logic [CW-1:0] mispred_cnt;

  branch_predict_unit #(
    .DATA_W    (DW),
    .PC_W      (PW),
    .BHT_DEPTH (DEP),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_stall      (ex_stall),
    .ex_op         (ex_op),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic          rt;
    logic          mp;
    logic [PW-1:0] rpc;
    int            cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // reference state
  int            m_bht [DEP];
  logic          m_rt;
  logic          m_mp;
  logic [PW-1:0] m_rpc;
  int            m_cnt;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s got %0h want %0h", name, act, exp);
  endfunction

  function automatic int idx(logic [PW-1:0] pc);
    return int'((pc >> 2) % DEP);
  endfunction

  function automatic logic ref_taken(int op, logic [DW-1:0] rs, logic [DW-1:0] rt);
    longint s;
    s = longint'($signed(rs));
    case (op)
      0: return rs == rt;
      1: return rs != rt;
      2: return s >= 0;
      3: return s > 0;
      4: return s <= 0;
      5: return s < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEP; i++) m_bht[i] = 1;
    m_rt = 0; m_mp = 0; m_rpc = '0; m_cnt = 0;
  endfunction

  task automatic drive(int op, logic [DW-1:0] rs, logic [DW-1:0] rt,
                       logic [PW-1:0] pc, logic [PW-1:0] tgt, logic pred,
                       logic v, logic s, logic [PW-1:0] ipc);
    exp_t e;
    logic t;
    logic acc;
    @(negedge clk);
    ex_op = 3'(op); ex_rs = rs; ex_rt = rt; ex_pc = pc;
    ex_target = tgt; ex_pred_taken = pred;
    ex_valid = v; ex_stall = s; if_pc = ipc;
    #1;
    chk("if_pred_taken", longint'(if_pred_taken), longint'(m_bht[idx(ipc)] >= 2));
    acc = v && !s;
    t = ref_taken(op, rs, rt);
    if (acc) begin
      m_rt  = t;
      m_mp  = (t != pred);
      m_rpc = t ? tgt : pc + 32'd4;
      if (m_mp && m_cnt < (1 << CW) - 1) m_cnt++;
      if (op <= 5) begin
        if (t && m_bht[idx(pc)] < 3) m_bht[idx(pc)]++;
        if (!t && m_bht[idx(pc)] > 0) m_bht[idx(pc)]--;
      end
    end
    e.rv = acc; e.rt = m_rt; e.mp = acc && m_mp;
    e.rpc = m_rpc; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic idle(logic [PW-1:0] ipc);
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, ipc);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_res_valid"}, longint'(res_valid), 0);
    chk({tag, "_res_taken"}, longint'(res_taken), 0);
    chk({tag, "_mispredict"}, longint'(mispredict), 0);
    chk({tag, "_redirect_pc"}, longint'(redirect_pc), 0);
    chk({tag, "_mispred_cnt"}, longint'(mispred_cnt), 0);
  endtask

  // monitor: one expected entry per driven cycle, compared after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("res_valid", longint'(res_valid), longint'(e.rv));
        chk("res_taken", longint'(res_taken), longint'(e.rt));
        chk("mispredict", longint'(mispredict), longint'(e.mp));
        chk("redirect_pc", longint'(redirect_pc), longint'(e.rpc));
        chk("mispred_cnt", longint'(mispred_cnt), longint'(e.cnt));
      end
    end
  end

  logic [DW-1:0] vals [4];

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_stall = 0; ex_op = 0; ex_rs = 0; ex_rt = 0;
    ex_pc = 0; ex_target = 0; ex_pred_taken = 0; if_pc = 0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle(32'h0040_0000);
    // taken beq, mispredicted
    drive(0, 5, 5, 32'h100, 32'h200, 0, 1, 0, 32'h100);
    idle(32'h100);

    vals[0] = 32'h0; vals[1] = 32'h1;
    vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
    for (int op = 2; op <= 5; op++)
      for (int i = 0; i < 4; i++)
        drive(op, vals[i], 0, 32'h80, 32'h300, 0, 1, 0, 32'h80);

    // saturation on one entry; lookup same index during update
    for (int i = 0; i < 4; i++)
      drive(0, 1, 1, 32'h44, 32'h500, 1, 1, 0, 32'h44);
    drive(1, 1, 1, 32'h44, 32'h500, 1, 1, 0, 32'h44);
    idle(32'h44);

    // stall, then wrap of pc+4
    drive(0, 1, 1, 32'h48, 32'h600, 0, 1, 1, 32'h48);
    idle(32'h48);
    drive(1, 7, 7, 32'hFFFF_FFFC, 32'h700, 1, 1, 0, 32'h8);
    drive(6, 0, 0, 32'h4C, 32'h800, 1, 1, 0, 32'h4C);

    // counter saturation
    for (int i = 0; i < 20; i++)
      drive(0, 1, 2, 32'h50, 32'h900, 1, 1, 0, 32'h50);

    // async reset mid-stream
    @(negedge clk);
    ex_valid = 1'b1;
    rst_n = 1'b0;
    model_reset();
    q.delete();
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b0;
    for (int i = 0; i < DEP; i++)
      drive(0, 3, 3, 32'(i * 4), 32'h40, 1, 1, 0, 32'(i * 4));
    for (int i = 0; i < DEP; i++)
      idle(32'(i * 4));

    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] rs;
      logic [DW-1:0] rt;
      logic [PW-1:0] pc;
      rs = ($urandom_range(0, 1) == 0) ? vals[$urandom_range(0, 3)] : $urandom;
      rt = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      pc = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_FF00;
      drive(int'($urandom_range(0, 7)), rs, rt, pc, $urandom & ~32'h3,
            1'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
            ($urandom_range(0, 1) == 0) ? pc : 32'($urandom_range(0, 63)) << 2);
    end

    idle(0);
    @(negedge clk);
    chk("queue_drained", longint'(q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
